fir_coef_loader: RTL and testbench

FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

---
 rtl/fir_coef_pkg.sv | 15 +
 rtl/fir_coef_debounce.sv | 43 ++++
 rtl/fir_coef_loader.sv | 99 +++++++++
 tb/tb_fir_coef_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_coef_pkg.sv
// Shared types and sizes for the FIR coefficient loader.
// COEF_W / REG_W give the default coefficient and register-word widths.
package fir_coef_pkg;

  localparam int COEF_W = 16;
  localparam int REG_W  = 2 * COEF_W;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ARMED  = 2'd2
  } state_t;

endpackage

// File: rtl/fir_coef_debounce.sv
// Purpose: flags when a data word has been unchanged for STABLE_CYC consecutive enabled cycles.
// Latency: combinational stable flag on the cycle the count is reached; history is registered.
// Backpressure: none; the count restarts whenever en drops or din changes.
module fir_coef_debounce #(
  parameter int DATA_W     = 32,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic              stable
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_nxt;
  logic [DATA_W-1:0] prev_q;

  // First enabled cycle or a changed word counts as one sighting of the new value.
  always_comb begin
    cnt_nxt = cnt_q;
    if ((cnt_q == '0) || (din != prev_q)) begin
      cnt_nxt = CW'(1);
    end else if (cnt_q < CW'(STABLE_CYC)) begin
      cnt_nxt = cnt_q + CW'(1);
    end
  end

  assign stable = en && (cnt_nxt >= CW'(STABLE_CYC));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      prev_q <= '0;
    end else begin
      cnt_q  <= en ? cnt_nxt : '0;
      prev_q <= din;
    end
  end

endmodule

// File: rtl/fir_coef_loader.sv
// Purpose: shadows software FIR coefficients and swaps them in on a frame sync (FIR_COEF_LOADER_DEBOUNCE_EN adds input debounce).
// Latency: coefficients change 1 cycle after the arming sync_in, aligned with sync_out.
// Backpressure: none; a commit edge while an update is pending is dropped and flagged in overrun.
module fir_coef_loader #(
  parameter int COEF_W = fir_coef_pkg::COEF_W
`ifdef FIR_COEF_LOADER_DEBOUNCE_EN
  ,
  parameter int STABLE_CYC = 4
`endif
) (
  input  logic                           user_clk,
  input  logic                           user_rst,
  input  logic [2*COEF_W-1:0]            reg_data,
  input  logic                           commit,
  input  logic                           sync_in,
  output logic                           sync_out,
  output logic [COEF_W-1:0]              coef_even,
  output logic [COEF_W-1:0]              coef_odd,
  output logic                           coef_valid,
  output logic                           pending,
  output logic                           overrun,
  output logic [fir_coef_pkg::CNT_W-1:0] update_cnt
);

  import fir_coef_pkg::*;

  localparam int RW = 2 * COEF_W;

  state_t            state_q;
  state_t            state_nxt;
  logic              commit_q;
  logic              commit_edge;
  logic              settle_done;
  logic              swap;
  logic [RW-1:0]     shadow_q;
  logic [CNT_W-1:0]  cnt_q;

  assign commit_edge = commit && !commit_q;
  assign pending     = (state_q == ST_SETTLE) || (state_q == ST_ARMED);
  assign swap        = (state_q == ST_ARMED) && sync_in;
  assign update_cnt  = cnt_q;

`ifdef FIR_COEF_LOADER_DEBOUNCE_EN
  fir_coef_debounce #(
    .DATA_W     (RW),
    .STABLE_CYC (STABLE_CYC)
  ) u_debounce (
    .clk    (user_clk),
    .rst    (user_rst),
    .en     (state_q == ST_SETTLE),
    .din    (reg_data),
    .stable (settle_done)
  );
`else
  assign settle_done = 1'b1;
`endif

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (commit_edge) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_nxt = ST_ARMED;
      ST_ARMED:  if (sync_in)     state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q    <= ST_IDLE;
      commit_q   <= 1'b0;
      sync_out   <= 1'b0;
      shadow_q   <= '0;
      coef_even  <= '0;
      coef_odd   <= '0;
      coef_valid <= 1'b0;
      overrun    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q  <= state_nxt;
      commit_q <= commit;
      sync_out <= sync_in;
      // Shadow tracks reg_data only while settling; frozen once armed.
      if (state_q == ST_SETTLE) begin
        shadow_q <= reg_data;
      end
      if (swap) begin
        coef_even  <= shadow_q[RW-1 -: COEF_W];
        coef_odd   <= shadow_q[COEF_W-1:0];
        coef_valid <= 1'b1;
        cnt_q      <= cnt_q + CNT_W'(1);
      end
      if (commit_edge && pending) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: swap timing, overrun, sync alignment, counter wrap, reset abort.
`timescale 1ns/1ps
module tb_fir_coef_loader;

`ifdef FIR_COEF_LOADER_DEBOUNCE_EN
  localparam int SETTLE_TICKS = 4;
`else
  localparam int SETTLE_TICKS = 1;
`endif

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic [31:0] reg_data;
  logic        commit;
  logic        sync_in;
  logic        sync_out;
  logic [15:0] coef_even;
  logic [15:0] coef_odd;
  logic        coef_valid;
  logic        pending;
  logic        overrun;
  logic [15:0] update_cnt;

  int n_vec = 0;
  int n_err = 0;

  fir_coef_loader dut (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .reg_data   (reg_data),
    .commit     (commit),
    .sync_in    (sync_in),
    .sync_out   (sync_out),
    .coef_even  (coef_even),
    .coef_odd   (coef_odd),
    .coef_valid (coef_valid),
    .pending    (pending),
    .overrun    (overrun),
    .update_cnt (update_cnt)
  );

  always #5 user_clk = ~user_clk;

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Commit edge followed by enough cycles to reach ARMED with stable reg_data.
  task automatic arm(input logic [31:0] word);
    commit = 1'b0;
    tick();
    commit   = 1'b1;
    reg_data = word;
    tick();
    repeat (SETTLE_TICKS) tick();
  endtask

  task automatic pulse_sync();
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
  endtask

  initial begin
    user_rst = 1'b1;
    commit   = 1'b0;
    sync_in  = 1'b0;
    reg_data = 32'h0;
    repeat (3) tick();
    check("rst_even",    32'(coef_even),  32'h0);
    check("rst_odd",     32'(coef_odd),   32'h0);
    check("rst_valid",   32'(coef_valid), 32'h0);
    check("rst_pending", 32'(pending),    32'h0);
    check("rst_overrun", 32'(overrun),    32'h0);
    check("rst_cnt",     32'(update_cnt), 32'h0);
    check("rst_syncout", 32'(sync_out),   32'h0);

`ifdef FIR_COEF_LOADER_DEBOUNCE_EN
    user_rst = 1'b0;
    commit   = 1'b1;
    reg_data = 32'hAAAA5555;
    tick();
    for (int i = 0; i < 3; i++) begin
      reg_data = 32'h0000FFFF;
      repeat (2) tick();
      reg_data = 32'hAAAA5555;
      repeat (2) tick();
      check("deb_toggle_pending", 32'(pending), 32'h1);
    end
    reg_data = 32'h0000FFFF;
    repeat (3) tick();
    pulse_sync();
    check("deb_early_sync_valid", 32'(coef_valid), 32'h0);
    check("deb_early_sync_cnt",   32'(update_cnt), 32'h0);
    tick();
    pulse_sync();
    check("deb_even",  32'(coef_even),  32'h0000);
    check("deb_odd",   32'(coef_odd),   32'hFFFF);
    check("deb_valid", 32'(coef_valid), 32'h1);
    user_rst = 1'b1;
    commit   = 1'b0;
    tick();
`endif

    // Basic update: sync 10 cycles after commit, reg_data change while armed ignored.
    user_rst = 1'b0;
    reg_data = 32'h12345678;
    commit   = 1'b1;
    tick();
    check("basic_pending", 32'(pending), 32'h1);
    repeat (SETTLE_TICKS) tick();
    reg_data = 32'hDEADBEEF;
    repeat (8) tick();
    check("basic_pre_even",  32'(coef_even),  32'h0);
    check("basic_pre_valid", 32'(coef_valid), 32'h0);
    pulse_sync();
    check("basic_even",    32'(coef_even),  32'h1234);
    check("basic_odd",     32'(coef_odd),   32'h5678);
    check("basic_valid",   32'(coef_valid), 32'h1);
    check("basic_cnt",     32'(update_cnt), 32'h1);
    check("basic_syncout", 32'(sync_out),   32'h1);
    check("basic_idle",    32'(pending),    32'h0);
    tick();
    check("basic_syncout_low", 32'(sync_out),  32'h0);
    check("basic_hold_even",   32'(coef_even), 32'h1234);

    // Second commit edge while armed: overrun, single swap.
    arm(32'h11112222);
    commit = 1'b0;
    tick();
    commit = 1'b1;
    tick();
    check("ovr_flag",    32'(overrun), 32'h1);
    check("ovr_pending", 32'(pending), 32'h1);
    pulse_sync();
    check("ovr_even", 32'(coef_even),  32'h1111);
    check("ovr_odd",  32'(coef_odd),   32'h2222);
    check("ovr_cnt",  32'(update_cnt), 32'h2);
    tick();
    pulse_sync();
    check("idle_sync_even", 32'(coef_even),  32'h1111);
    check("idle_sync_cnt",  32'(update_cnt), 32'h2);
    check("ovr_sticky",     32'(overrun),    32'h1);

    // sync_in on the cycle ARMED is entered must not swap.
    commit = 1'b0;
    tick();
    commit   = 1'b1;
    reg_data = 32'h33334444;
    tick();
    repeat (SETTLE_TICKS - 1) tick();
    pulse_sync();
    check("enter_sync_even",    32'(coef_even), 32'h1111);
    check("enter_sync_pending", 32'(pending),   32'h1);
    check("enter_sync_syncout", 32'(sync_out),  32'h1);
    tick();
    pulse_sync();
    check("next_sync_even", 32'(coef_even),  32'h3333);
    check("next_sync_odd",  32'(coef_odd),   32'h4444);
    check("next_sync_cnt",  32'(update_cnt), 32'h3);

    // Counter wrap from 0xFFFF.
    force dut.cnt_q = 16'hFFFF;
    tick();
    release dut.cnt_q;
    check("wrap_preload", 32'(update_cnt), 32'hFFFF);
    arm(32'h55556666);
    pulse_sync();
    check("wrap_cnt",  32'(update_cnt), 32'h0);
    check("wrap_even", 32'(coef_even),  32'h5555);

    // Reset while armed discards the update; sync_out still tracks sync_in afterwards.
    arm(32'h77778888);
    check("abort_pending", 32'(pending), 32'h1);
    user_rst = 1'b1;
    commit   = 1'b0;
    tick();
    check("abort_even",    32'(coef_even),  32'h0);
    check("abort_valid",   32'(coef_valid), 32'h0);
    check("abort_cnt",     32'(update_cnt), 32'h0);
    check("abort_overrun", 32'(overrun),    32'h0);
    check("abort_pend",    32'(pending),    32'h0);
    user_rst = 1'b0;
    tick();
    pulse_sync();
    check("abort_sync_even",    32'(coef_even),  32'h0);
    check("abort_sync_odd",     32'(coef_odd),   32'h0);
    check("abort_sync_valid",   32'(coef_valid), 32'h0);
    check("abort_sync_syncout", 32'(sync_out),   32'h1);
    tick();
    check("abort_syncout_low", 32'(sync_out), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
